mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between the PROCESSOR fetch port (I) and load/store port (D).
//  - Grants one request per cycle; D has priority, with a bounded-starvation override for I.
//  - Tracks outstanding reads in order and routes each returned word back to its requester.
//  - Sits between the PROCESSOR pipeline and the memory model/BRAM wrapper.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_tag_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared tag constants and width helper for the memory port arbiter.
// No logic. No flow control.
package mem_arb_pkg;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// 1-bit x DEPTH in-order FIFO holding the requester of each outstanding read.
// Latency: push visible at head next cycle; head is combinational from storage.
// Backpressure: push ignored when full unless popped the same cycle.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic                    i_tag,
  input  logic                    i_pop,
  output logic                    o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rptr];

  // When full, the slot being written is the head being popped; the read is
  // taken combinationally before the edge, so the overlap is safe.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_tag;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) ports.
// Latency: zero-cycle grant; read data passes straight through from memory.
// Backpressure: m_ready stalls grants; reads held off when MAX_OUT are outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int STARVE  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy,
  output logic            err
);

  localparam int CW = clog2(MAX_OUT) + 1;
  localparam int SW = clog2(STARVE + 1);

  logic [SW-1:0] r_streak;
  logic          r_err;
  logic          w_starved;
  logic          w_sel_i;
  logic          w_sel_d;
  logic          w_room;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  assign w_starved = (r_streak == SW'(STARVE));
  assign w_sel_i   = i_req & (~d_req | w_starved);
  assign w_sel_d   = d_req & ~w_sel_i;

  // A full tag FIFO only blocks reads; a same-cycle response frees a slot.
  assign w_room = ~w_full | m_rvalid | (w_sel_d & d_we);
  assign m_req  = rst_n & (w_sel_i | w_sel_d) & w_room;

  assign m_we    = w_sel_d & d_we;
  assign m_be    = w_sel_d ? d_be : '1;
  assign m_addr  = w_sel_d ? d_addr : i_addr;
  assign m_wdata = d_wdata;

  assign w_acc  = m_req & m_ready;
  assign i_gnt  = w_acc & w_sel_i;
  assign d_gnt  = w_acc & w_sel_d;
  assign w_push = w_acc & ~m_we;
  assign w_pop  = m_rvalid & ~w_empty;

  assign i_rvalid = rst_n & w_pop & (w_head == TAG_I);
  assign d_rvalid = rst_n & w_pop & (w_head == TAG_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign busy     = (w_count != '0);
  assign err      = r_err;

  mem_arb_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_tag   (w_sel_d ? TAG_D : TAG_I),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
      r_err    <= 1'b0;
    end else begin
      if (m_rvalid && w_empty) r_err <= 1'b1;
      if (!i_req || i_gnt)                r_streak <= '0;
      else if (d_gnt && !w_starved)       r_streak <= r_streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector table plus hand sequences for mem_port_arbiter; read routing checked
// against a queue of expected requester tags.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic        busy, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb[$];
  bit err_m = 1'b0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_OUT(4), .STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [3:0]  dbe;
    logic [31:0] da, wd;
    logic        mrdy, mrv;
    logic [31:0] mrd;
    logic        eig, edg, emreq, emwe;
    logic [3:0]  embe;
    logic [31:0] emaddr;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dwe, logic [3:0] dbe,
                              logic [31:0] da, logic [31:0] wd, logic mrdy, logic mrv,
                              logic [31:0] mrd, logic eig, logic edg, logic emreq, logic emwe,
                              logic [3:0] embe, logic [31:0] emaddr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.wd = wd;
    v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
    v.eig = eig; v.edg = edg; v.emreq = emreq; v.emwe = emwe; v.embe = embe; v.emaddr = emaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    bit has;
    bit tag;
    i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_we = v.dwe; d_be = v.dbe;
    d_addr = v.da; d_wdata = v.wd; m_ready = v.mrdy; m_rvalid = v.mrv; m_rdata = v.mrd;
    @(negedge clk);
    has = v.mrv && (sb.size() > 0);
    tag = has ? sb[0] : 1'b0;
    chk("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
    chk("err", {31'd0, err}, {31'd0, err_m});
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, v.eig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.edg});
    chk("m_req", {31'd0, m_req}, {31'd0, v.emreq});
    if (v.emreq) begin
      chk("m_we", {31'd0, m_we}, {31'd0, v.emwe});
      chk("m_be", {28'd0, m_be}, {28'd0, v.embe});
      chk("m_addr", m_addr, v.emaddr);
      if (v.emwe) chk("m_wdata", m_wdata, v.wd);
    end
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, has && !tag});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, has && tag});
    if (has && !tag) chk("i_rdata", i_rdata, v.mrd);
    if (has && tag)  chk("d_rdata", d_rdata, v.mrd);
    if (has) void'(sb.pop_front());
    else if (v.mrv) err_m = 1'b1;
    if (v.eig) sb.push_back(1'b0);
    if (v.edg && !v.dwe) sb.push_back(1'b1);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[21];
  vec_t cv;

  initial begin
    tbl[0]  = mk(1,'h40, 0,0,'hF,0,0,       1,0,0,          1,0,1,0,'hF,'h40);
    tbl[1]  = mk(0,0,    0,0,'hF,0,0,       1,1,'h8C080000, 0,0,0,0,'hF,0);
    tbl[2]  = mk(1,'h100,0,0,'hF,0,0,       1,0,0,          1,0,1,0,'hF,'h100);
    tbl[3]  = mk(0,0,    1,0,'hF,'h200,0,   1,0,0,          0,1,1,0,'hF,'h200);
    tbl[4]  = mk(0,0,    1,0,'hF,'h204,0,   1,0,0,          0,1,1,0,'hF,'h204);
    tbl[5]  = mk(1,'h104,0,0,'hF,0,0,       1,0,0,          1,0,1,0,'hF,'h104);
    tbl[6]  = mk(1,'h108,0,0,'hF,0,0,       1,0,0,          0,0,0,0,'hF,0);
    tbl[7]  = mk(1,'h108,1,1,'h3,'h300,'h1234, 1,0,0,       0,1,1,1,'h3,'h300);
    tbl[8]  = mk(1,'h108,0,0,'hF,0,0,       1,1,'hA,        1,0,1,0,'hF,'h108);
    tbl[9]  = mk(0,0,    0,0,'hF,0,0,       1,1,'hB,        0,0,0,0,'hF,0);
    tbl[10] = mk(0,0,    0,0,'hF,0,0,       1,1,'hC,        0,0,0,0,'hF,0);
    tbl[11] = mk(0,0,    0,0,'hF,0,0,       1,1,'hD,        0,0,0,0,'hF,0);
    tbl[12] = mk(0,0,    0,0,'hF,0,0,       1,1,'hE,        0,0,0,0,'hF,0);
    tbl[13] = mk(0,0,    0,0,'hF,0,0,       1,0,0,          0,0,0,0,'hF,0);
    tbl[14] = mk(0,0,    0,0,'hF,0,0,       1,1,'hFF,       0,0,0,0,'hF,0);
    tbl[15] = mk(0,0,    1,1,'h3,'h10,'h55, 1,0,0,          0,1,1,1,'h3,'h10);
    tbl[16] = mk(0,0,    0,0,'hF,0,0,       1,0,0,          0,0,0,0,'hF,0);
    tbl[17] = mk(1,'h500,0,0,'hF,0,0,       0,0,0,          0,0,1,0,'hF,'h500);
    tbl[18] = mk(1,'h500,0,0,'hF,0,0,       1,0,0,          1,0,1,0,'hF,'h500);
    tbl[19] = mk(0,0,    0,0,'hF,0,0,       1,1,'h77,       0,0,0,0,'hF,0);
    tbl[20] = mk(0,0,    0,0,'hF,0,0,       1,0,0,          0,0,0,0,'hF,0);

    // Reset asserted at time zero with a fetch pending.
    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h40; d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    d_addr = '0; d_wdata = '0; m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    #3;
    chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) apply(tbl[k]);

    // Sustained contention: four D grants then one forced I grant.
    for (int k = 0; k < 15; k++) begin
      cv = mk(1,'h600, 1,0,'hF,'h700,0, 1,(k > 0),k, 0,0,1,0,'hF,0);
      cv.eig    = (k % 5 == 4);
      cv.edg    = !cv.eig;
      cv.emaddr = cv.eig ? 32'h600 : 32'h700;
      apply(cv);
    end
    apply(mk(0,0,0,0,'hF,0,0, 1,1,'hEE, 0,0,0,0,'hF,0));

    // Reset mid-operation with a read outstanding; its late response is spurious.
    apply(mk(1,'h800,0,0,'hF,0,0, 1,0,0, 1,0,1,0,'hF,'h800));
    i_req = 1'b1; m_rvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("mid_rst_m_req", {31'd0, m_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    sb.delete();
    err_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(mk(0,0,0,0,'hF,0,0, 1,1,'h99, 0,0,0,0,'hF,0));
    apply(mk(0,0,0,0,'hF,0,0, 1,0,0,    0,0,0,0,'hF,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
